// File: rtl/cache_pkg.sv
// cache_pkg: shared types and line-geometry helper for the cache/memory sequencing blocks.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IC_FILL,
        ST_DC_WB,
        ST_DC_FILL,
        ST_DONE
    } mem_arb_state_t;

    typedef enum logic {
        REQ_IC,
        REQ_DC
    } requester_t;

    // Byte-offset width of a line: word index bits plus two byte-in-word bits.
    function automatic int line_off_w(input int words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

endpackage

// File: rtl/mem_arb_beat_cnt.sv
// mem_arb_beat_cnt: word-beat index within a line burst; wraps to 0 after the last beat.
module mem_arb_beat_cnt #(
    parameter int N = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 clr,
    input  logic                 inc,
    output logic [$clog2(N)-1:0] idx,
    output logic                 last
);
    localparam int W = $clog2(N);

    always_ff @(posedge CLK) begin
        if (RST || clr)
            idx <= '0;
        else if (inc)
            idx <= idx + W'(1);
    end

    assign last = idx == W'(N - 1);

endmodule

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: arbitrates I/D cache line transfers onto one MM port as word bursts.
// Tie-break: fixed DC priority, or alternating when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_line_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              ic_req,
    input  logic [ADDR_W-1:0]                 ic_addr,
    output logic [DATA_W-1:0]                 ic_rdata,
    output logic                              ic_rvalid,
    output logic [$clog2(WORDS_PER_LINE)-1:0] ic_word_idx,
    output logic                              ic_done,
    input  logic                              dc_req,
    input  logic                              dc_we,
    input  logic [ADDR_W-1:0]                 dc_addr,
    input  logic [DATA_W-1:0]                 dc_wdata,
    output logic [DATA_W-1:0]                 dc_rdata,
    output logic                              dc_rvalid,
    output logic [$clog2(WORDS_PER_LINE)-1:0] dc_word_idx,
    output logic                              dc_done,
    output logic                              mm_req,
    output logic                              mm_we,
    output logic [ADDR_W-1:0]                 mm_addr,
    output logic [DATA_W-1:0]                 mm_wdata,
    input  logic [DATA_W-1:0]                 mm_rdata,
    input  logic                              mm_ack
);
    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam int OFF   = line_off_w(WORDS_PER_LINE);
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF){1'b1}}, {OFF{1'b0}}};

    mem_arb_state_t    state;
    requester_t        owner;
    logic [ADDR_W-1:0] base;
    logic [IDX_W-1:0]  idx;
    logic              last, xfer, beat, dc_wins;

    assign xfer = state inside {ST_IC_FILL, ST_DC_WB, ST_DC_FILL};
    assign beat = xfer && mm_ack;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // owner doubles as last_grant: it is rewritten at every grant.
    assign dc_wins = owner == REQ_IC;
`else
    assign dc_wins = 1'b1;
`endif

    mem_arb_beat_cnt #(.N(WORDS_PER_LINE)) u_cnt (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (state == ST_IDLE),
        .inc  (beat),
        .idx  (idx),
        .last (last)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            owner <= REQ_IC;
            base  <= '0;
        end else begin
            case (state)
                ST_IDLE:
                    if (dc_req && (!ic_req || dc_wins)) begin
                        state <= dc_we ? ST_DC_WB : ST_DC_FILL;
                        owner <= REQ_DC;
                        base  <= dc_addr & LINE_MASK;
                    end else if (ic_req) begin
                        state <= ST_IC_FILL;
                        owner <= REQ_IC;
                        base  <= ic_addr & LINE_MASK;
                    end
                ST_IC_FILL, ST_DC_WB, ST_DC_FILL:
                    if (beat && last)
                        state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mm_req      = xfer;
    assign mm_we       = state == ST_DC_WB;
    assign mm_addr     = xfer ? base + (ADDR_W'(idx) << 2) : '0;
    assign mm_wdata    = mm_we ? dc_wdata : '0;
    assign ic_rvalid   = state == ST_IC_FILL && mm_ack;
    assign dc_rvalid   = state == ST_DC_FILL && mm_ack;
    assign ic_rdata    = ic_rvalid ? mm_rdata : '0;
    assign dc_rdata    = dc_rvalid ? mm_rdata : '0;
    assign ic_word_idx = idx;
    assign dc_word_idx = idx;
    assign ic_done     = state == ST_DONE && owner == REQ_IC;
    assign dc_done     = state == ST_DONE && owner == REQ_DC;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter: directed vector table for an IC fill plus hand-written multi-cycle sequences.
module tb_mem_line_arbiter;
    logic        CLK = 0, RST = 1;
    logic        ic_req = 0, dc_req = 0, dc_we = 0, mm_ack = 0;
    logic [31:0] ic_addr = 0, dc_addr = 0, dc_wdata, mm_rdata;
    logic [31:0] ic_rdata, dc_rdata, mm_addr, mm_wdata;
    logic [2:0]  ic_word_idx, dc_word_idx;
    logic        ic_rvalid, ic_done, dc_rvalid, dc_done, mm_req, mm_we;
    int          total = 0, bad = 0;
    bit          last_dc = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rpat(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] wpat(input int k);
        return 32'hD000_0000 + 32'(k) * 32'h11;
    endfunction

    // Memory returns an address-derived word; the D-cache supplies a pattern per word index.
    assign mm_rdata = rpat(mm_addr);
    assign dc_wdata = wpat(int'(dc_word_idx));

    mem_line_arbiter dut (
        .CLK(CLK), .RST(RST),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid),
        .ic_word_idx(ic_word_idx), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_word_idx(dc_word_idx), .dc_done(dc_done),
        .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
        .mm_rdata(mm_rdata), .mm_ack(mm_ack)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic chk_zero(input string n);
        chk(n, 64'(|{ic_rdata, ic_rvalid, ic_word_idx, ic_done, dc_rdata, dc_rvalid, dc_word_idx,
                     dc_done, mm_req, mm_we, mm_addr, mm_wdata}), 0);
    endtask

    function automatic bit tie_dc();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return !last_dc;
`else
        return 1'b1;
`endif
    endfunction

    // Runs one granted line from the current (idle) cycle through its done pulse.
    task automatic serve(input string n, input int per, input bit dc, input bit wb,
                         input logic [31:0] base, input int lat, input int raise_dc_at);
        int beats = 0, cyc = 0, done_cyc = -1;
        while (done_cyc < 0 && cyc < 200) begin
            mm_ack = per <= 1 ? 1'b1 : (cyc % per == per - 1);
            if (raise_dc_at >= 0 && beats == raise_dc_at) dc_req = 1;
            @(negedge CLK);
            if (mm_req && mm_ack) begin
                chk({n, ".addr"}, mm_addr, base + 32'(beats) * 4);
                chk({n, ".we"}, mm_we, wb);
                chk({n, ".idx"}, dc ? dc_word_idx : ic_word_idx, beats);
                if (wb) chk({n, ".wdata"}, mm_wdata, wpat(beats));
                else chk({n, ".rdata"}, dc ? dc_rdata : ic_rdata, rpat(base + 32'(beats) * 4));
                chk({n, ".rv_own"}, dc ? dc_rvalid : ic_rvalid, !wb);
                chk({n, ".rv_other"}, dc ? ic_rvalid : dc_rvalid, 0);
                beats++;
            end
            if (ic_done || dc_done) begin
                chk({n, ".done_owner"}, {ic_done, dc_done}, dc ? 2'b01 : 2'b10);
                chk({n, ".done_mmreq"}, mm_req, 0);
                done_cyc = cyc;
                if (dc) dc_req = 0; else ic_req = 0;
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        chk({n, ".beats"}, beats, 8);
        if (done_cyc < 0) chk({n, ".timeout"}, 1, 0);
        else if (lat >= 0) chk({n, ".latency"}, done_cyc, lat);
        last_dc = dc;
    endtask

    typedef struct {
        logic        ic_req;
        logic        mm_ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_rv;
        logic [2:0]  e_idx;
        logic        e_done;
    } vec_t;

    vec_t v[11];

    initial begin
        bit first;
        v[0] = '{1, 1, 0, 32'h0, 0, 3'd0, 0};
        for (int k = 0; k < 8; k++) v[k+1] = '{1, 1, 1, 32'h100 + 32'(k) * 4, 1, 3'(k), 0};
        v[9]  = '{0, 1, 0, 32'h0, 0, 3'd0, 1};
        v[10] = '{0, 1, 0, 32'h0, 0, 3'd0, 0};

        repeat (2) @(posedge CLK);
        #1;
        chk_zero("reset_outputs");
        RST = 0;
        last_dc = 0;

        ic_addr = 32'h0000_0104;
        for (int i = 0; i < 11; i++) begin
            ic_req = v[i].ic_req;
            mm_ack = v[i].mm_ack;
            @(negedge CLK);
            chk($sformatf("vec%0d.mm_req", i), mm_req, v[i].e_req);
            chk($sformatf("vec%0d.mm_addr", i), mm_addr, v[i].e_addr);
            chk($sformatf("vec%0d.ic_rvalid", i), ic_rvalid, v[i].e_rv);
            chk($sformatf("vec%0d.ic_rdata", i), ic_rdata, v[i].e_rv ? rpat(v[i].e_addr) : 32'h0);
            chk($sformatf("vec%0d.ic_idx", i), ic_word_idx, v[i].e_idx);
            chk($sformatf("vec%0d.ic_done", i), ic_done, v[i].e_done);
            chk($sformatf("vec%0d.mm_we", i), mm_we, 0);
            chk($sformatf("vec%0d.dc_done", i), dc_done, 0);
            @(posedge CLK);
            #1;
        end
        last_dc = 0;

        dc_addr = 32'h2000; dc_we = 1; dc_req = 1;
        serve("dc_wb", 3, 1, 1, 32'h2000, 24, -1);

        ic_addr = 32'h0000_0610; dc_addr = 32'h0000_7000; dc_we = 0; ic_req = 1;
        serve("ic_mid", 1, 0, 0, 32'h600, 9, 4);
        serve("dc_after_ic", 1, 1, 0, 32'h7000, 9, -1);

        dc_addr = 32'h5008; dc_we = 0; dc_req = 1; mm_ack = 1;
        repeat (4) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("rst_pre.dc_idx", dc_word_idx, 3);
        chk("rst_pre.mm_addr", mm_addr, 32'h500C);
        RST = 1; dc_req = 0;
        @(posedge CLK);
        #1;
        RST = 0;
        last_dc = 0;
        @(negedge CLK);
        chk("rst_post.mm_req", mm_req, 0);
        chk("rst_post.dc_done", dc_done, 0);
        chk_zero("rst_post.zero");
        @(posedge CLK);
        #1;
        dc_req = 1;
        serve("dc_refill", 1, 1, 0, 32'h5000, 9, -1);

        ic_req = 0; dc_req = 0; mm_ack = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("idle_ack%0d", i), mm_req, 0);
            chk_zero($sformatf("idle_ack%0d.zero", i));
            @(posedge CLK);
            #1;
        end

        ic_addr = 32'h3000; dc_addr = 32'h4000; dc_we = 0;
        for (int t = 0; t < 2; t++) begin
            ic_req = 1; dc_req = 1;
            first = tie_dc();
            serve($sformatf("tie%0d_first", t), 1, first, 0, first ? 32'h4000 : 32'h3000, 9, -1);
            serve($sformatf("tie%0d_second", t), 1, !first, 0, first ? 32'h3000 : 32'h4000, 9, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
